// File: rtl/sm3_pkg.sv
// SM3 shared definitions: FSM state encoding, command codes, round
// constants, initial vector and the small bit-level helpers used by both
// the round datapath and the message schedule.
package sm3_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, COMP, FINAL, READ} state_t;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_LOAD  = 3'b010;
  localparam logic [2:0] CMD_CHAIN = 3'b110;

  localparam logic [31:0] T_LO = 32'h79CC4519;  // rounds 0-15
  localparam logic [31:0] T_HI = 32'h7A879D8A;  // rounds 16-63

  // Word 0 of V is index 0 (A).
  localparam logic [7:0][31:0] IV = {
    32'hB0FB0E4E, 32'hE38DEE4D, 32'h163138AA, 32'hA96F30BC,
    32'hDA8A0600, 32'h172442D7, 32'h4914B2B9, 32'h7380166F
  };

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction

endpackage

// File: rtl/sm3_round.sv
// One SM3 compression round, purely combinational.
// Ports:
//   s     - working registers A..H (index 0 = A)
//   wj    - expanded message word Wj
//   wpj   - Wj xor W(j+4)
//   tj    - unrotated round constant for this round's group
//   j     - round index 0..63 (selects boolean functions and Tj rotation)
//   s_nxt - A..H after the round
module sm3_round
  import sm3_pkg::*;
(
  input  logic [7:0][31:0] s,
  input  logic [31:0]      wj,
  input  logic [31:0]      wpj,
  input  logic [31:0]      tj,
  input  logic [5:0]       j,
  output logic [7:0][31:0] s_nxt
);

  logic [31:0] a12, ss1, ss2, ff, gg, tt1, tt2;
  logic        lo;

  always_comb begin
    lo  = (j < 6'd16);
    a12 = rotl(s[0], 5'd12);
    // Tj is rotated by j mod 32, hence only the low five index bits.
    ss1 = rotl(a12 + s[4] + rotl(tj, j[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    ff  = lo ? (s[0] ^ s[1] ^ s[2])
             : ((s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]));
    gg  = lo ? (s[4] ^ s[5] ^ s[6])
             : ((s[4] & s[5]) | (~s[4] & s[6]));
    tt1 = ff + s[3] + ss2 + wpj;
    tt2 = gg + s[7] + ss1 + wj;
    s_nxt[0] = tt1;
    s_nxt[1] = s[0];
    s_nxt[2] = rotl(s[1], 5'd9);
    s_nxt[3] = s[2];
    s_nxt[4] = p0(tt2);
    s_nxt[5] = s[4];
    s_nxt[6] = rotl(s[5], 5'd19);
    s_nxt[7] = s[6];
  end

endmodule

// File: rtl/ars_sm3.sv
// SM3 hash core: loads one pre-padded 512-bit block as 16 words, runs 64
// rounds (one per cycle) with a sliding 16-word message schedule, folds the
// result into V, and reads V out word by word.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   din           - message word, sampled during LOAD
//   dout          - digest word during readout (holds V7 afterwards)
//   cmd_i,cmd_w_i - command code and strobe (001 read, 010 load, 110 chain)
//   cmd_o         - {busy, last accepted command}
//   read_counter  - word index during load (0-15) or readout (0-7)
// Build option: define ARS_SM3_CHAIN_EN to let command 110 continue from the
// current V; otherwise 110 behaves as 010 and every block starts from IV.
module ars_sm3
  import sm3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [2:0]  cmd_i,
  input  logic        cmd_w_i,
  output logic [3:0]  cmd_o,
  output logic [3:0]  read_counter
);

  state_t state, state_nxt;

  logic [7:0][31:0]  v;       // chaining value
  logic [7:0][31:0]  r;       // working registers A..H
  logic [7:0][31:0]  r_nxt;
  logic [15:0][31:0] win;     // win[0] is Wj for the current round
  logic [31:0]       wnew;
  logic [5:0]        rnd;
  logic [2:0]        ridx;
  logic [2:0]        last_cmd;
  logic              accept, is_read, is_load, from_iv;
  logic [31:0]       tj;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = is_read ? READ : LOAD;
      LOAD:  if (read_counter == 4'd15) state_nxt = COMP;
      COMP:  if (rnd == 6'd63) state_nxt = FINAL;
      FINAL: state_nxt = IDLE;
      READ:  if (ridx == 3'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    is_read = (cmd_i == CMD_READ);
    is_load = (cmd_i == CMD_LOAD) || (cmd_i == CMD_CHAIN);
    accept  = cmd_w_i && (state == IDLE) && (is_read || is_load);
`ifdef ARS_SM3_CHAIN_EN
    from_iv = (cmd_i == CMD_LOAD);
`else
    from_iv = is_load;
`endif
    tj    = (rnd < 6'd16) ? T_LO : T_HI;
    cmd_o = {state != IDLE, last_cmd};
  end

  // Next schedule word W(j+16) from the window holding Wj..W(j+15).
  assign wnew = p1(win[0] ^ win[7] ^ rotl(win[13], 5'd15))
              ^ rotl(win[3], 5'd7) ^ win[10];

  sm3_round u_round (
    .s     (r),
    .wj    (win[0]),
    .wpj   (win[0] ^ win[4]),
    .tj    (tj),
    .j     (rnd),
    .s_nxt (r_nxt)
  );

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v            <= IV;
      r            <= '0;
      win          <= '0;
      rnd          <= '0;
      ridx         <= '0;
      read_counter <= '0;
      dout         <= '0;
      last_cmd     <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          last_cmd     <= cmd_i;
          read_counter <= '0;
          ridx         <= '0;
          if (from_iv) v <= IV;
        end
        LOAD: begin
          win          <= {din, win[15:1]};
          read_counter <= read_counter + 4'd1;  // wraps to 0 after W15
          if (read_counter == 4'd15) begin
            r   <= v;
            rnd <= '0;
          end
        end
        COMP: begin
          r   <= r_nxt;
          win <= {wnew, win[15:1]};
          rnd <= rnd + 6'd1;
        end
        FINAL: v <= v ^ r;
        READ: begin
          dout         <= v[ridx];
          read_counter <= {1'b0, ridx};
          ridx         <= ridx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ars_sm3.sv
// Self-checking bench for ars_sm3: known-answer vectors, command filtering,
// load/readout timing, mid-compression reset and random blocks checked
// against a straightforward SM3 compression-function model.
module tb_ars_sm3;

  typedef logic [7:0][31:0]  v_t;    // index 0 = V0
  typedef logic [15:0][31:0] blk_t;  // index 0 = W0

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic [31:0] dout;
  logic [2:0]  cmd_i;
  logic        cmd_w_i;
  logic [3:0]  cmd_o;
  logic [3:0]  read_counter;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_last;

  ars_sm3 dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .dout         (dout),
    .cmd_i        (cmd_i),
    .cmd_w_i      (cmd_w_i),
    .cmd_o        (cmd_o),
    .read_counter (read_counter)
  );

  always #5 clk = ~clk;

  localparam v_t IV_M = {
    32'hB0FB0E4E, 32'hE38DEE4D, 32'h163138AA, 32'hA96F30BC,
    32'hDA8A0600, 32'h172442D7, 32'h4914B2B9, 32'h7380166F
  };
  localparam v_t EXP_ABC = {
    32'h8F4BA8E0, 32'h297DA02B, 32'h5CF2F7A2, 32'h4167C487,
    32'hDC10E4E2, 32'hD1F2D46B, 32'h62EEEDD9, 32'h66C7F0F4
  };
  localparam v_t EXP_ABCD = {
    32'h9C0C5732, 32'h293DCBA3, 32'h387E5765, 32'h6FDB70E5,
    32'hC18E5A4D, 32'h38604889, 32'h2275B8A1, 32'hDEBE9FF9
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  function automatic v_t cf(input v_t v, input blk_t blk);
    logic [31:0] w [68];
    logic [31:0] a, b, c, d, e, f, g, h, t, ss1, ss2, ff, gg, tt1, tt2, x;
    for (int j = 0; j < 16; j++) w[j] = blk[j];
    for (int j = 16; j < 68; j++) begin
      x = w[j-16] ^ w[j-9] ^ rl(w[j-3], 15);
      w[j] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(w[j-13], 7) ^ w[j-6];
    end
    a = v[0]; b = v[1]; c = v[2]; d = v[3];
    e = v[4]; f = v[5]; g = v[6]; h = v[7];
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79CC4519 : 32'h7A879D8A;
      ss1 = rl(rl(a, 12) + e + rl(t, j), 7);
      ss2 = ss1 ^ rl(a, 12);
      if (j < 16) begin
        ff = a ^ b ^ c;
        gg = e ^ f ^ g;
      end else begin
        ff = (a & b) | (a & c) | (b & c);
        gg = (e & f) | (~e & g);
      end
      tt1 = ff + d + ss2 + (w[j] ^ w[j+4]);
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rl(b, 9); b = a; a = tt1;
      h = g; g = rl(f, 19); f = e; e = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
    end
    return v ^ {h, g, f, e, d, c, b, a};
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic strobe(input logic [2:0] c);
    @(negedge clk);
    cmd_i   = c;
    cmd_w_i = 1'b1;
    @(negedge clk);
    cmd_w_i = 1'b0;
  endtask

  task automatic load(input blk_t blk, input logic [2:0] c, input bit busy_poke);
    int n, sc;
    strobe(c);
    exp_last = c;
    chk("load_busy_rise", cmd_o[3], 1'b1);
    for (int i = 0; i < 16; i++) begin
      din = blk[i];
      chk("load_cnt", read_counter, i);
      @(negedge clk);
    end
    n  = 0;
    sc = $urandom_range(2, 60);
    while (cmd_o[3] && n < 200) begin
      if (busy_poke && n == sc) begin
        cmd_i   = 3'($urandom_range(0, 7));
        cmd_w_i = 1'b1;
      end else begin
        cmd_w_i = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    cmd_w_i = 1'b0;
    chk("load_latency", n, 65);
    chk("cmd_kept", cmd_o[2:0], exp_last);
  endtask

  task automatic read_chk(input v_t exp, input string tag);
    strobe(3'b001);
    exp_last = 3'b001;
    chk({tag, "_busy_rise"}, cmd_o[3], 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk({tag, "_word"}, dout, exp[k]);
      chk({tag, "_cnt"}, read_counter, k);
      chk({tag, "_busy"}, cmd_o[3], (k < 7) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    chk({tag, "_hold"}, dout, exp[7]);
  endtask

  task automatic bad_cmd(input logic [2:0] c);
    strobe(c);
    chk("bad_busy", cmd_o[3], 1'b0);
    chk("bad_last", cmd_o[2:0], exp_last);
    @(negedge clk);
    chk("bad_busy2", cmd_o[3], 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    blk_t abc, abcd, pad, rb;
    v_t   vm;
    logic [2:0] c;
    logic [2:0] bad [5];
    bad = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b111};

    reset = 1'b1; cmd_w_i = 1'b0; cmd_i = '0; din = '0;
    abc  = '0; abc[0] = 32'h61626380; abc[15] = 32'h00000018;
    abcd = '0; for (int i = 0; i < 16; i++) abcd[i] = 32'h61626364;
    pad  = '0; pad[0] = 32'h80000000; pad[15] = 32'h00000200;
    exp_last = 3'b000;
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_cmd_o", cmd_o, 0);
    chk("rst_cnt", read_counter, 0);
    reset = 1'b0;

    // V comes out of reset as IV
    read_chk(IV_M, "rd_iv");

    // "abc" known answer
    load(abc, 3'b010, 1'b0);
    read_chk(EXP_ABC, "rd_abc");

    // Unknown code while idle
    bad_cmd(3'b111);

    // Two-block message, second block via chain command
    load(abcd, 3'b010, 1'b1);
    vm = cf(IV_M, abcd);
    load(pad, 3'b110, 1'b1);
`ifdef ARS_SM3_CHAIN_EN
    read_chk(EXP_ABCD, "rd_abcd");
`else
    vm = cf(IV_M, pad);
    read_chk(vm, "rd_nochain");
`endif

    // Reset during round 30 of an "abc" block
    strobe(3'b010);
    for (int i = 0; i < 16; i++) begin
      din = abc[i];
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_cmd_o", cmd_o, 0);
    chk("mid_rst_cnt", read_counter, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_last = 3'b000;
    read_chk(IV_M, "rd_after_rst");
    load(abc, 3'b010, 1'b0);
    read_chk(EXP_ABC, "rd_abc2");

    // Random blocks against the model
    vm = EXP_ABC;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) rb[i] = $urandom;
      c = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b110;
`ifdef ARS_SM3_CHAIN_EN
      if (c == 3'b010) vm = IV_M;
`else
      vm = IV_M;
`endif
      vm = cf(vm, rb);
      load(rb, c, 1'b1);
      read_chk(vm, "rd_rand");
      bad_cmd(bad[$urandom_range(0, 4)]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
